// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared word width, trace entry type, clear FSM states and byte-merge helper
//
// Used by data_mem_bank and trace_fifo.

package mem_pkg;

  localparam int WORD_W = 32;

  // One write-trace record: issuing pc, word-aligned byte address, merged word.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } trace_entry_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  // Replace the byte lanes selected by be, keep the others from old_w.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [3:0]        be
  );
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - write-trace FIFO with sticky overflow on push-while-full
//
// Parameters:
//   TRACE_DEPTH  entries, power of two (2..64)
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   push_i                    enqueue push_{pc,addr,data}_i this cycle
//   push_pc_i/addr_i/data_i   entry fields to enqueue
//   pop_i                     dequeue the head (ignored while empty)
//   head_pc_o/addr_o/data_o   current head entry (registered storage)
//   full_o, empty_o           occupancy flags
//   overflow_o                sticky: a push was discarded because the FIFO was full

module trace_fifo
  import mem_pkg::*;
#(
  parameter int TRACE_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_pc_i,
  input  logic [WORD_W-1:0] push_addr_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_pc_o,
  output logic [WORD_W-1:0] head_addr_o,
  output logic [WORD_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(TRACE_DEPTH);

  trace_entry_t  store_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          overflow_q;

  logic          do_push;
  logic          do_pop;
  trace_entry_t  push_entry;
  trace_entry_t  head_entry;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign push_entry.pc   = push_pc_i;
  assign push_entry.addr = push_addr_i;
  assign push_entry.data = push_data_i;

  assign head_entry  = store_q[rd_ptr_q];
  assign head_pc_o   = head_entry.pc;
  assign head_addr_o = head_entry.addr;
  assign head_data_o = head_entry.data;
  assign overflow_o  = overflow_q;

  // Pointers are PW bits wide, so the increment wraps modulo TRACE_DEPTH.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (push_i && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; only valid slots are ever observed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - word-addressed data memory with post-reset clear sweep and write trace
//
// Optional feature macro: DATA_MEM_TRACE_EN (write-trace FIFO; tied off when undefined).
// Parameters:
//   DEPTH        32-bit words, power of two (16..65536)
//   TRACE_DEPTH  write-trace FIFO entries, power of two (2..64)
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   addr              byte address; word index = addr[31:2]
//   wdata, byteen     write data and per-byte enables (all zero = read only)
//   pc                issuing instruction address, recorded in the trace
//   rdata             combinational read of mem[index mod DEPTH], 0 while busy
//   busy              high while the clear sweep runs
//   fault             one-cycle pulse after a rejected out-of-range write
//   trace_valid/ready handshake of the write-trace stream
//   trace_pc/addr/data head trace entry (0 when the stream is empty)
//   trace_overflow    sticky: a trace entry was dropped because the FIFO was full

module data_mem_bank
  import mem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        byteen,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              fault,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [WORD_W-1:0] trace_pc,
  output logic [WORD_W-1:0] trace_addr,
  output logic [WORD_W-1:0] trace_data,
  output logic              trace_overflow
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  logic [WORD_W-1:0] mem_q [DEPTH];

  clr_state_t        state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic              fault_q;

  logic [AW-1:0]     word_idx;
  logic              in_range;
  logic              wr_req;
  logic              wr_accept;
  logic              wr_oor;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] merged_word;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // Low AW bits of the word index give the natural "index mod DEPTH".
  assign word_idx = addr[AW+1:2];
  assign in_range = ({2'b00, addr[31:2]} < 32'(DEPTH));

  // Reset is folded in so busy/rdata are defined before the first edge.
  assign busy     = reset || (state_q == ST_CLEAR);
  assign cur_word = mem_q[word_idx];
  assign rdata    = busy ? '0 : cur_word;
  assign fault    = fault_q;

  assign wr_req      = (|byteen) && !busy;
  assign wr_accept   = wr_req && in_range;
  assign wr_oor      = wr_req && !in_range;
  assign merged_word = merge_bytes(cur_word, wdata, byteen);

  // The single memory write port is shared by the clear sweep and accesses.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = merged_word;
    if (!reset && (state_q == ST_CLEAR)) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Clear FSM: one word per cycle from 0 to DEPTH-1, then idle until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= wr_oor;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CNT_ONE;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DATA_MEM_TRACE_EN
  logic              fifo_empty;
  logic              unused_fifo_full;
  logic [WORD_W-1:0] head_pc;
  logic [WORD_W-1:0] head_addr;
  logic [WORD_W-1:0] head_data;

  trace_fifo #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (wr_accept),
    .push_pc_i  (pc),
    .push_addr_i({addr[31:2], 2'b00}),
    .push_data_i(merged_word),
    .pop_i      (trace_ready),
    .head_pc_o  (head_pc),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .full_o     (unused_fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (trace_overflow)
  );

  // Stale storage is masked so an empty stream reads as all zero.
  assign trace_valid = !fifo_empty;
  assign trace_pc    = fifo_empty ? '0 : head_pc;
  assign trace_addr  = fifo_empty ? '0 : head_addr;
  assign trace_data  = fifo_empty ? '0 : head_data;
`else
  logic unused_trace;

  assign unused_trace   = ^{trace_ready, pc, addr[1:0]};
  assign trace_valid    = 1'b0;
  assign trace_pc       = '0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_bank.sv
// tb/tb_data_mem_bank.sv - self-checking bench for data_mem_bank
module tb_data_mem_bank;

  localparam int DEPTH = 4096;
  localparam int TD    = 8;
`ifdef DATA_MEM_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        busy;
  logic        fault;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  data_mem_bank #(
    .DEPTH(DEPTH),
    .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byteen(byteen), .pc(pc),
    .rdata(rdata), .busy(busy), .fault(fault),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  // Reference model: memory array, trace queue, sticky overflow, fault pulse.
  logic [31:0] mm [DEPTH];
  tr_t         tq[$];
  logic        m_ovf;
  logic        m_fault;

  int checks = 0;
  int errors = 0;

  function automatic tr_t model_head();
    tr_t h;
    h.pc = 0; h.addr = 0; h.data = 0;
    if (tq.size() > 0) h = tq[0];
    return h;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (int'(a >> 2)) % DEPTH;
  endfunction

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic [31:0] p, input logic rdy);
    logic [31:0] w;
    bit inr, popd, was_full;
    tr_t e;
    inr = ((a >> 2) < DEPTH);
    m_fault = (be != 4'h0) && !inr;
    popd = rdy && (tq.size() > 0);
    was_full = (tq.size() == TD);
    if (popd) void'(tq.pop_front());
    if (be != 4'h0 && inr) begin
      w = mm[word_of(a)];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      mm[word_of(a)] = w;
      if (TRACE_EN) begin
        if (was_full && !popd) m_ovf = 1'b1;
        else begin
          e.pc = p; e.addr = a & 32'hFFFF_FFFC; e.data = w;
          tq.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] p, input logic rdy);
    addr = a; wdata = d; byteen = be; pc = p; trace_ready = rdy;
    @(posedge clk);
    model_edge(a, d, be, p, rdy);
    #1;
    byteen = 4'h0; trace_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    tq.delete();
    m_ovf = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; byteen = 4'h0; trace_ready = 1'b0; addr = 32'h0;
    step(); step();
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0 || fault !== 1'b0 || trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b rdata=%h fault=%b tv=%b ovf=%b required 1 00000000 0 0 0",
               busy, rdata, fault, trace_valid, trace_overflow);
    end
    reset = 1'b0;
    n = 0;
    // Writes driven during the sweep must be ignored (no fault, no trace).
    while (busy === 1'b1 && n < 10000) begin
      addr = n[0] ? 32'h0000_4000 : 32'h0; wdata = 32'hDEAD_BEEF; byteen = 4'hF; pc = 32'h0;
      #1;
      checks++;
      if (rdata !== 32'h0 || fault !== 1'b0 || trace_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy_io n=%0d rdata=%h fault=%b tv=%b required 0 0 0", n, rdata, fault, trace_valid);
      end
      n++;
      @(posedge clk); #1;
    end
    byteen = 4'h0;
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_length busy cycles=%0d required %0d", n, DEPTH);
    end
    model_reset();
    addr = 32'h0; #1;
    checks++;
    if (rdata !== 32'h0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL post_clear_read0 rdata=%h fault=%b required 0 0", rdata, fault);
    end
    for (int k = 0; k < 6; k++) begin
      addr = 32'($urandom_range(0, DEPTH-1)) << 2; #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL post_clear_read addr=%h got=%h required 00000000", addr, rdata);
      end
    end
  endtask

  task automatic test_trace_drain(input int exp_n);
    int n;
    tr_t h;
    n = 0;
    while (trace_valid === 1'b1 && n < 64) begin
      h = model_head();
      checks++;
      if (trace_pc !== h.pc || trace_addr !== h.addr || trace_data !== h.data) begin
        errors++;
        $display("FAIL drain_entry %0d got pc=%h addr=%h data=%h required pc=%h addr=%h data=%h",
                 n, trace_pc, trace_addr, trace_data, h.pc, h.addr, h.data);
      end
      cyc(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
      n++;
    end
    checks++;
    if (n != exp_n || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_count got=%0d tv=%b required %0d 0", n, trace_valid, exp_n);
    end
  endtask

  task automatic test_byte_lanes();
    tr_t h;
    cyc(32'h10, 32'h1122_3344, 4'b1111, 32'h0000_0100, 1'b0);
    cyc(32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0000_0104, 1'b0);
    addr = 32'h10; #1;
    checks++;
    if (rdata !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL byte_lanes rdata=%h required 11bb33dd", rdata);
    end
    h = model_head();
    checks++;
    if (trace_valid !== TRACE_EN || trace_pc !== h.pc || trace_addr !== h.addr || trace_data !== h.data) begin
      errors++;
      $display("FAIL byte_lanes_trace tv=%b pc=%h addr=%h data=%h required %b %h %h %h",
               trace_valid, trace_pc, trace_addr, trace_data, TRACE_EN, h.pc, h.addr, h.data);
    end
    test_trace_drain(tq.size());
  endtask

  task automatic test_out_of_range();
    cyc(32'h0, 32'hCAFE_F00D, 4'hF, 32'h200, 1'b0);
    cyc(32'h0000_4000, 32'h1234_5678, 4'hF, 32'h204, 1'b0);
    checks++;
    if (fault !== 1'b1 || m_fault !== 1'b1) begin
      errors++;
      $display("FAIL oor_fault_pulse fault=%b required 1", fault);
    end
    checks++;
    if (trace_valid !== (tq.size() > 0) || trace_data !== model_head().data) begin
      errors++;
      $display("FAIL oor_no_trace tv=%b data=%h required %b %h", trace_valid, trace_data, tq.size() > 0, model_head().data);
    end
    cyc(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL oor_fault_width fault=%b required 0", fault);
    end
    cyc(32'hFFFF_FFF0, 32'h5555_5555, 4'b0010, 32'h208, 1'b0);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL oor_high_fault fault=%b required 1", fault);
    end
    addr = 32'h0000_4000; #1;
    checks++;
    if (rdata !== 32'hCAFE_F00D || rdata !== mm[0]) begin
      errors++;
      $display("FAIL oor_mem0 rdata=%h required cafef00d", rdata);
    end
    test_trace_drain(tq.size());
  endtask

  task automatic test_trace_overflow();
    logic [31:0] a1, d1;
    for (int i = 0; i < 9; i++) begin
      logic [31:0] a, d;
      a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      if (i == 0) begin a1 = a; d1 = d; end
      cyc(a, d, 4'hF, 32'h0000_1000 + 32'(4*i), 1'b0);
    end
    checks++;
    if (trace_overflow !== m_ovf || trace_overflow !== TRACE_EN || trace_valid !== TRACE_EN) begin
      errors++;
      $display("FAIL overflow_flag ovf=%b tv=%b required %b %b", trace_overflow, trace_valid, TRACE_EN, TRACE_EN);
    end
    checks++;
    if (trace_valid === 1'b1 &&
        (trace_pc !== 32'h0000_1000 || trace_addr !== (a1 & 32'hFFFF_FFFC) || trace_data !== d1)) begin
      errors++;
      $display("FAIL overflow_first pc=%h addr=%h data=%h required 00001000 %h %h",
               trace_pc, trace_addr, trace_data, a1 & 32'hFFFF_FFFC, d1);
    end
    test_trace_drain(TRACE_EN ? TD : 0);
    checks++;
    if (trace_overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow_sticky ovf=%b required %b", trace_overflow, m_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    tr_t h;
    for (int i = 0; i < TD; i++) cyc(32'(4*i), $urandom, 4'hF, 32'h0000_2000 + 32'(4*i), 1'b0);
    cyc(32'h0000_0100, 32'h0BAD_F00D, 4'hF, 32'h0000_2100, 1'b1);
    h = model_head();
    checks++;
    if (trace_overflow !== 1'b0 || trace_valid !== TRACE_EN || trace_pc !== h.pc || trace_data !== h.data) begin
      errors++;
      $display("FAIL push_pop_full ovf=%b tv=%b pc=%h data=%h required 0 %b %h %h",
               trace_overflow, trace_valid, trace_pc, trace_data, TRACE_EN, h.pc, h.data);
    end
    test_trace_drain(TRACE_EN ? TD : 0);
    checks++;
    if (trace_overflow !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full_ovf ovf=%b required 0", trace_overflow);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0] be;
    logic rdy;
    tr_t h;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h0000_4000 + (32'($urandom_range(0, 1023)) << 2);
        1:       a = $urandom | 32'h8000_0000;
        default: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      endcase
      d = $urandom;
      be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      rdy = 1'($urandom_range(0, 1));
      addr = a; byteen = 4'h0; #1;
      checks++;
      if (rdata !== mm[word_of(a)]) begin
        errors++;
        $display("FAIL rand_read i=%0d addr=%h got=%h required %h", i, a, rdata, mm[word_of(a)]);
      end
      cyc(a, d, be, 32'($urandom), rdy);
      h = model_head();
      checks++;
      if (fault !== m_fault || trace_overflow !== m_ovf || trace_valid !== (tq.size() > 0) ||
          trace_pc !== h.pc || trace_addr !== h.addr || trace_data !== h.data) begin
        errors++;
        $display("FAIL rand_state i=%0d fault=%b ovf=%b tv=%b pc=%h addr=%h data=%h required %b %b %b %h %h %h",
                 i, fault, trace_overflow, trace_valid, trace_pc, trace_addr, trace_data,
                 m_fault, m_ovf, tq.size() > 0, h.pc, h.addr, h.data);
      end
    end
    test_trace_drain(tq.size());
  endtask

  task automatic test_reset_mid_clear();
    int n;
    cyc(32'h0, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
    cyc(32'd200, 32'h2222_2222, 4'hF, 32'h0, 1'b0);
    cyc(32'h0000_3FFC, 32'h3333_3333, 4'hF, 32'h0, 1'b0);
    reset = 1'b1; step(); step();
    reset = 1'b0;
    repeat (100) step();
    reset = 1'b1; step();
    checks++;
    if (busy !== 1'b1 || rdata !== 32'h0 || trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset busy=%b rdata=%h tv=%b required 1 0 0", busy, rdata, trace_valid);
    end
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 10000) begin
      n++;
      step();
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL mid_clear_length busy cycles=%0d required %0d", n, DEPTH);
    end
    model_reset();
    addr = 32'h0000_3FFC; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_clear_last_word rdata=%h required 0", rdata);
    end
    addr = 32'd200; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_clear_word50 rdata=%h required 0", rdata);
    end
  endtask

  initial begin
    reset = 1'b1; addr = 32'h0; wdata = 32'h0; byteen = 4'h0; pc = 32'h0; trace_ready = 1'b0;
    m_ovf = 1'b0; m_fault = 1'b0;
    test_reset();
    test_byte_lanes();
    test_out_of_range();
    test_trace_overflow();
    test_reset();
    test_push_pop_full();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bank.md
DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter TRACE_DEPTH, default 8, write-trace FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  byte address of the access.
REQ-006 SHALL have port wdata  input  32  write data, byte lanes aligned to the word.
REQ-007 SHALL have port byteen  input  4  per-byte write enable; all zero means read only.
REQ-008 SHALL have port pc  input  32  address of the instruction issuing the access, for trace.
REQ-009 SHALL have port rdata  output  32  read word.
REQ-010 SHALL have port busy  output  1  high while the post-reset clear is running.
REQ-011 SHALL have port fault  output  1  one-cycle pulse flagging a rejected out-of-range write.
REQ-012 SHALL have ports trace_valid out 1, trace_ready in 1, trace_pc out 32, trace_addr out 32, trace_data out 32, and trace_overflow out 1: the write-trace stream.

Function
REQ-013 SHALL compute word index = addr[31:2]; in range when index < DEPTH.
REQ-014 SHALL drive rdata combinationally as mem[index mod DEPTH] when busy is low, and 0 while busy.
REQ-015 SHALL accept a write when |byteen, busy low, reset low and index in range; each lane with byteen[i] set replaces byte i and other bytes are kept.
REQ-016 SHALL drop an out-of-range write (memory unchanged, no trace entry) and assert fault on the following cycle for exactly one cycle.
REQ-017 SHALL ignore writes while busy: no memory change, no fault, no trace.
REQ-018 SHALL implement FSM CLEAR/IDLE. Reset forces CLEAR with counter 0. In CLEAR with reset low, each cycle writes 0 to mem[counter] and increments the counter. After writing DEPTH-1, it goes to IDLE.
REQ-019 SHALL make busy = (state == CLEAR), so busy falls exactly DEPTH cycles after reset deasserts.
REQ-020 SHALL push {pc, addr & 32'hFFFFFFFC, merged word} into the trace FIFO for every accepted write. The entry is visible on trace_* one cycle later.
REQ-021 SHALL pop the head entry when trace_valid && trace_ready; trace_valid is high iff the FIFO is non-empty.
REQ-022 SHALL hold trace_pc, trace_addr and trace_data stable while trace_valid && !trace_ready.
REQ-023 SHALL, on push with FIFO full and no pop in the same cycle, discard the new entry and set trace_overflow sticky.
REQ-024 SHALL complete both operations when push and pop occur in the same cycle at full, with the count unchanged and no overflow.
REQ-025 SHALL wrap FIFO pointers modulo TRACE_DEPTH.

Reset
REQ-026 SHALL, while reset is high, set state CLEAR, counter 0, FIFO empty, fault 0, trace_overflow 0 and trace_valid 0. It SHALL drive busy 1 and rdata 0.
REQ-027 SHALL restart the clear from word 0 when reset is asserted mid-clear.
REQ-028 SHALL not rely on reset-time bulk initialisation of memory contents; clearing is done only by the CLEAR sweep.

Configuration
REQ-029 SHALL, with macro DATA_MEM_TRACE_EN defined, instantiate the trace FIFO as specified.
REQ-030 SHALL, without DATA_MEM_TRACE_EN, keep all trace ports but tie trace_valid, trace_pc, trace_addr, trace_data and trace_overflow to 0 and ignore trace_ready. Memory behaviour is unchanged.

Structure
REQ-031 SHALL place in shared package mem_pkg: WORD_W = 32, the trace entry struct {pc, addr, data}, and the CLEAR/IDLE state enum.
REQ-032 SHALL implement the FIFO as sub-module trace_fifo (parameter TRACE_DEPTH, push/pop/full/empty/overflow).

Verification
REQ-033 SHALL check reset for 2 cycles, then release -> busy high for exactly 4096 cycles; reading 0x0 during and after the clear -> 0.
REQ-034 SHALL check a write to 0x10 with wdata 0x11223344 and byteen 4'b1111, then a write to 0x10 with wdata 0xAABBCCDD and byteen 4'b0101 -> rdata at 0x10 = 0x11BB33DD.
REQ-035 SHALL check a write to 0x4000 with byteen 4'b1111 and DEPTH 4096 -> fault high for one cycle, no trace entry, mem[0] unchanged.
REQ-036 SHALL check 9 writes with trace_ready held 0 and TRACE_DEPTH 8 -> 8 entries retained, trace_overflow 1; after raising trace_ready, the first entry drains with the pc, addr and data of write 1.
REQ-037 SHALL check a simultaneous push and pop at full -> the count stays 8, trace_overflow stays 0, and output order is preserved.
REQ-038 SHALL check reset asserted at clear counter 100 -> busy remains high for a full DEPTH cycles after the new release.
